// File: rtl/ternary_mac_vec.sv
// ternary_mac_vec: multi-lane ternary dot-product MAC with pass/accumulate modes, saturation and back-pressure.
// Define TERNARY_MAC_VEC_ZSKIP_CNT_EN to build the zero-weight lane counter; otherwise zero_skip_cnt is tied to 0.
module ternary_mac_vec #(
   parameter int LANES       = 4,
   parameter int ACT_BITS    = 16,
   parameter int ACC_BITS    = 32,
   parameter int PIPE_STAGES = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         clear,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic                         in_mode,
   input  logic                         in_last,
   input  logic [LANES*ACT_BITS-1:0]    activation,
   input  logic [LANES*2-1:0]           weight,
   input  logic signed [ACC_BITS-1:0]   psum_in,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic signed [ACC_BITS-1:0]   psum_out,
   output logic                         sat_flag,
   output logic [31:0]                  zero_skip_cnt
);

   localparam int PROD_W = ACT_BITS + 1;
   localparam int DOT_W  = ACT_BITS + $clog2(LANES) + 1;
   localparam int SUM_W  = ACC_BITS + 1;

   function automatic logic sat_hit(input logic signed [SUM_W-1:0] v);
      return v[SUM_W-1] != v[SUM_W-2];
   endfunction

   function automatic logic signed [ACC_BITS-1:0] sat_acc(input logic signed [SUM_W-1:0] v);
      if (v[SUM_W-1] != v[SUM_W-2])
         return v[SUM_W-1] ? {1'b1, {(ACC_BITS-1){1'b0}}} : {1'b0, {(ACC_BITS-1){1'b1}}};
      return v[ACC_BITS-1:0];
   endfunction

   logic                        rdy_en;
   logic                        stall;
   logic                        accept;
   logic signed [PROD_W-1:0]    prod_p0 [LANES];

   logic                        vld_p1;
   logic                        mode_p1;
   logic                        last_p1;
   logic signed [ACC_BITS-1:0]  psum_p1;
   logic signed [PROD_W-1:0]    prod_p1 [LANES];

   logic signed [DOT_W-1:0]     dot_p1;
   logic signed [ACC_BITS-1:0]  base_p1;
   logic signed [SUM_W-1:0]     sum_p1;
   logic signed [ACC_BITS-1:0]  res_p1;
   logic                        clamp_p1;
   logic                        emit_p1;
   logic signed [ACC_BITS-1:0]  acc;

   // in_ready stays low until the first edge after reset release
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rdy_en <= 1'b0;
      else        rdy_en <= 1'b1;
   end

   assign stall    = out_valid && !out_ready;
   assign in_ready = rdy_en && !stall && !clear;
   assign accept   = in_valid && in_ready;

   // Stage 0: ternary decode, exact negation thanks to the extra product bit
   always_comb begin
      for (int i = 0; i < LANES; i++) begin
         case (weight[2*i +: 2])
            2'b00:   prod_p0[i] = -(PROD_W'($signed(activation[i*ACT_BITS +: ACT_BITS])));
            2'b10:   prod_p0[i] = PROD_W'($signed(activation[i*ACT_BITS +: ACT_BITS]));
            default: prod_p0[i] = '0;
         endcase
      end
   end

   generate
      if (PIPE_STAGES == 2) begin : g_pipe2
         // Stage 1: registered lane products and beat side-band
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)      vld_p1 <= 1'b0;
            else if (clear)  vld_p1 <= 1'b0;
            else if (!stall) vld_p1 <= accept;
         end

         always_ff @(posedge clk) begin
            if (!stall) begin
               prod_p1 <= prod_p0;
               psum_p1 <= psum_in;
               mode_p1 <= in_mode;
               last_p1 <= in_last;
            end
         end
      end else begin : g_pipe1
         always_comb begin
            vld_p1  = accept;
            prod_p1 = prod_p0;
            psum_p1 = psum_in;
            mode_p1 = in_mode;
            last_p1 = in_last;
         end
      end
   endgenerate

   // Stage 2: adder tree, final add against psum_in or the running sum, saturation
   always_comb begin
      dot_p1 = '0;
      for (int i = 0; i < LANES; i++)
         dot_p1 = dot_p1 + DOT_W'(prod_p1[i]);
      base_p1  = mode_p1 ? acc : psum_p1;
      sum_p1   = SUM_W'(base_p1) + SUM_W'(dot_p1);
      res_p1   = sat_acc(sum_p1);
      clamp_p1 = sat_hit(sum_p1);
      emit_p1  = vld_p1 && (!mode_p1 || last_p1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         psum_out  <= '0;
         acc       <= '0;
         sat_flag  <= 1'b0;
      end else if (clear) begin
         out_valid <= 1'b0;
         psum_out  <= '0;
         acc       <= '0;
         sat_flag  <= 1'b0;
      end else if (!stall) begin
         out_valid <= emit_p1;
         if (emit_p1)
            psum_out <= res_p1;
         if (vld_p1 && clamp_p1)
            sat_flag <= 1'b1;
         // Pass-mode beats leave the running sum alone so groups may interleave
         if (vld_p1 && mode_p1)
            acc <= last_p1 ? '0 : res_p1;
      end
   end

`ifdef TERNARY_MAC_VEC_ZSKIP_CNT_EN
   logic [31:0] zeros_p0;
   logic [31:0] zcnt;

   // Weight codes 01 and 11 are the zero lanes, so bit 0 alone identifies them
   always_comb begin
      zeros_p0 = '0;
      for (int i = 0; i < LANES; i++)
         zeros_p0 = zeros_p0 + 32'(weight[2*i]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      zcnt <= '0;
      else if (clear)  zcnt <= '0;
      else if (accept) zcnt <= zcnt + zeros_p0;
   end

   assign zero_skip_cnt = zcnt;
`else
   assign zero_skip_cnt = 32'd0;
`endif

endmodule
